// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU op sequencer
//   DEF_WIDTH : default operand/result width (16)
//   DEF_OPW   : default opcode / mux-select width (4, 16 slots)
//   OP_MUL    : opcode that runs the iterative multiply when ALU_MUL_EN is defined
//   state_t   : sequencer FSM states
package alu_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_OPW   = 4;

   localparam logic [3:0] OP_MUL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_MUL    = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative unsigned shift-add multiplier, one partial product per cycle
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : one-cycle pulse; loads a and b and clears counter/accumulator
//   a, b    : operands, sampled on start
//   done    : high during the last iteration cycle
//   product : full-width product, valid while done is high
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

   logic                 r_run;
   logic [4:0]           r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_mplier;

   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_next;

   // Partial product for the current bit: a shifted by the bit position.
   assign w_addend   = r_mplier[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
   assign w_acc_next = r_acc + w_addend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_run    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_a      <= '0;
         r_mplier <= '0;
      end else if (start) begin
         r_run    <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_a      <= a;
         r_mplier <= b;
      end else if (r_run) begin
         r_acc    <= w_acc_next;
         r_mplier <= r_mplier >> 1;
         if (r_cnt == LAST_CNT) begin
            r_run <= 1'b0;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   // The final partial product is folded in combinationally so the result
   // is available in the same cycle as the last iteration.
   assign done    = r_run && (r_cnt == LAST_CNT);
   assign product = w_acc_next;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer for the 16:1 ALU result mux (ALU_MUL_EN enables opcode 15 multiply)
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake; req_ready high only when idle
//   req_op, req_a, req_b : opcode and operands
//   alu_a, alu_b         : registered operands to the ALU functional units
//   mux_sel              : registered select of the result mux
//   mux_out              : selected result from the mux
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data, rsp_ovf    : result and multiply overflow
//   busy                 : high whenever not idle
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int OPW   = DEF_OPW
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OPW-1:0]    req_op,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [OPW-1:0]    mux_sel,
   input  logic [WIDTH-1:0]  mux_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_data,
   output logic              rsp_ovf,
   output logic              busy
);

   state_t              r_state;
   state_t              w_state_next;

   logic [WIDTH-1:0]    r_alu_a;
   logic [WIDTH-1:0]    r_alu_b;
   logic [OPW-1:0]      r_mux_sel;
   logic [WIDTH-1:0]    r_rsp_data;

   logic                w_accept;
   logic                w_is_mul;

   assign w_accept = (r_state == ST_IDLE) && req_valid;

`ifdef ALU_MUL_EN
   logic                r_rsp_ovf;
   logic                w_mul_done;
   logic [2*WIDTH-1:0]  w_product;

   assign w_is_mul = (req_op == OPW'(OP_MUL));

   // Operands are taken from the request port on the accept cycle, the same
   // values that land in alu_a/alu_b.
   alu_mul_iter #(
      .WIDTH   (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_accept && w_is_mul),
      .a       (req_a),
      .b       (req_b),
      .done    (w_mul_done),
      .product (w_product)
   );
`else
   assign w_is_mul = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_state_next = w_is_mul ? ST_MUL : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_state_next = ST_RESP;
         end
         ST_MUL: begin
`ifdef ALU_MUL_EN
            if (w_mul_done) begin
               w_state_next = ST_RESP;
            end
`else
            w_state_next = ST_IDLE;
`endif
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_mux_sel  <= '0;
         r_rsp_data <= '0;
`ifdef ALU_MUL_EN
         r_rsp_ovf  <= 1'b0;
`endif
      end else begin
         if (w_accept) begin
            r_alu_a   <= req_a;
            r_alu_b   <= req_b;
            r_mux_sel <= req_op;
         end
         // One settle cycle lets the registered operands ripple through the
         // functional units and the mux before the result is captured.
         if (r_state == ST_SETTLE) begin
            r_rsp_data <= mux_out;
`ifdef ALU_MUL_EN
            r_rsp_ovf  <= 1'b0;
`endif
         end
`ifdef ALU_MUL_EN
         if ((r_state == ST_MUL) && w_mul_done) begin
            r_rsp_data <= w_product[WIDTH-1:0];
            r_rsp_ovf  <= |w_product[2*WIDTH-1:WIDTH];
         end
`endif
      end
   end

   assign req_ready = (r_state == ST_IDLE);
   assign rsp_valid = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign mux_sel   = r_mux_sel;
   assign rsp_data  = r_rsp_data;
`ifdef ALU_MUL_EN
   assign rsp_ovf   = r_rsp_ovf;
`else
   assign rsp_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a latency/result model
module tb_alu_op_sequencer;

`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  mux_sel;
   logic [15:0] mux_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_ovf;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Stand-in for the ALU units and the 16:1 result mux.
   function automatic logic [15:0] alu_fn(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
      case (s)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a ^ b;
         4'd3:    return a + b;
         4'd4:    return a - b;
         4'd5:    return ~a;
         4'd6:    return a << 1;
         4'd7:    return a >> 1;
         default: return a ^ b;
      endcase
   endfunction

   assign mux_out = alu_fn(mux_sel, alu_a, alu_b);

   alu_op_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .mux_sel   (mux_sel),
      .mux_out   (mux_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_ovf   (rsp_ovf),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted op is outstanding for a fixed latency, then its
   // result is offered until taken.
   bit          m_armed  = 1'b0;
   bit          m_active = 1'b0;
   int          m_cyc    = 0;
   int          m_lat    = 0;
   logic [3:0]  m_sel    = '0;
   logic [15:0] m_a      = '0;
   logic [15:0] m_b      = '0;
   logic [15:0] m_data   = '0;
   logic        m_ovf    = 1'b0;

   always @(posedge clk) begin
      logic [31:0] prod;
      if (rst) begin
         m_armed  = 1'b1;
         m_active = 1'b0;
         m_sel    = '0;
         m_a      = '0;
         m_b      = '0;
      end else if (m_armed) begin
         if (!m_active) begin
            if (req_valid) begin
               m_active = 1'b1;
               m_cyc    = 1;
               m_sel    = req_op;
               m_a      = req_a;
               m_b      = req_b;
               if (MUL_EN && req_op == 4'hF) begin
                  prod   = {16'h0, req_a} * {16'h0, req_b};
                  m_lat  = 17;
                  m_data = prod[15:0];
                  m_ovf  = (prod[31:16] != 16'h0);
               end else begin
                  m_lat  = 2;
                  m_data = alu_fn(req_op, req_a, req_b);
                  m_ovf  = 1'b0;
               end
            end
         end else if (m_cyc < m_lat) begin
            m_cyc++;
         end else if (rsp_ready) begin
            m_active = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_armed) begin
         check("req_ready", req_ready, !m_active);
         check("busy", busy, m_active);
         check("rsp_valid", rsp_valid, m_active && (m_cyc == m_lat));
         check("alu_a", alu_a, m_a);
         check("alu_b", alu_b, m_b);
         check("mux_sel", mux_sel, m_sel);
         if (m_active && (m_cyc == m_lat)) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_ovf", rsp_ovf, m_ovf);
         end
      end
   end

   // Presents one request, waits for acceptance, then returns at the falling
   // edge of the first cycle rsp_valid is seen (lat = cycles after accept).
   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [3:0] sel1);
      bit accepted;
      accepted = 1'b0;
      lat      = 0;
      sel1     = 4'h0;
      @(posedge clk); #2;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clk);
         if (req_ready) accepted = 1'b1;
      end
      @(posedge clk); #2;
      req_valid = 1'b0;
      req_op    = 4'(~op);
      req_a     = 16'hDEAD;
      req_b     = 16'hBEEF;
      if (!accepted) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) sel1 = mux_sel;
            if (rsp_valid) begin
               lat = k;
               break;
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [3:0]  sel1;
      logic [15:0] d0;
      bit          seen;
      logic [15:0] ta [8];
      logic [15:0] tb [8];

      ta = '{16'hF0F0, 16'h1200, 16'hAAAA, 16'hFFFF, 16'h0001, 16'h5A5A, 16'h8001, 16'h8000};
      tb = '{16'h0FF0, 16'h0034, 16'h5555, 16'h0001, 16'h0002, 16'h0000, 16'h1111, 16'h2222};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      @(negedge clk);
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_mux_sel", mux_sel, 4'h0);
      check("reset_rsp_data", rsp_data, 16'h0000);
      check("reset_busy", busy, 1'b0);

      issue(4'h3, 16'h1234, 16'h0001, lat, sel1);
      check("op3_sel_cycle1", sel1, 4'h3);
      check("op3_latency", lat, 2);
      check("op3_data", rsp_data, 16'h1235);
      check("op3_ovf", rsp_ovf, 1'b0);

      for (int i = 0; i < 8; i++) begin
         issue(4'(i), ta[i], tb[i], lat, sel1);
         check("mux_op_latency", lat, 2);
      end

`ifdef ALU_MUL_EN
      issue(4'hF, 16'h0100, 16'h0003, lat, sel1);
      check("mul_latency", lat, 17);
      check("mul_sel", mux_sel, 4'hF);
      check("mul_data", rsp_data, 16'h0300);
      check("mul_ovf", rsp_ovf, 1'b0);

      issue(4'hF, 16'hFFFF, 16'h0002, lat, sel1);
      check("mul_ovf_latency", lat, 17);
      check("mul_ovf_data", rsp_data, 16'hFFFE);
      check("mul_ovf_flag", rsp_ovf, 1'b1);

      issue(4'hF, 16'h1234, 16'h5678, lat, sel1);
      check("mul_big_latency", lat, 17);
`else
      issue(4'hF, 16'h00F0, 16'h0F0F, lat, sel1);
      check("op15_sel_cycle1", sel1, 4'hF);
      check("op15_latency", lat, 2);
      check("op15_data", rsp_data, 16'h0FFF);
      check("op15_ovf", rsp_ovf, 1'b0);
`endif

      // Backpressure: result held, no acceptance until after the handshake.
      @(posedge clk); #2;
      rsp_ready = 1'b0;
      issue(4'h2, 16'h00FF, 16'h0F0F, lat, sel1);
      check("bp_latency", lat, 2);
      d0 = rsp_data;
      check("bp_data", d0, 16'h0FF0);
      req_valid = 1'b1;
      req_op    = 4'h1;
      req_a     = 16'h00AA;
      req_b     = 16'h0055;
      repeat (5) begin
         @(negedge clk);
         check("bp_hold_valid", rsp_valid, 1'b1);
         check("bp_hold_data", rsp_data, d0);
         check("bp_hold_req_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_ready", req_ready, 1'b1);
      check("bp_not_yet_accepted", mux_sel, 4'h2);
      @(negedge clk);
      check("bp_accepted_sel", mux_sel, 4'h1);
      check("bp_accepted_busy", busy, 1'b1);
      req_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("bp_second_rsp_seen", seen, 1'b1);
      check("bp_second_data", rsp_data, 16'h00FF);

      // Reset in the middle of an op: no response ever appears.
      @(posedge clk); #2;
      req_valid = 1'b1;
      req_op    = 4'hF;
      req_a     = 16'h0003;
      req_b     = 16'h0005;
      @(negedge clk);
      check("abort_ready_before", req_ready, 1'b1);
      @(posedge clk); #2;
      req_valid = 1'b0;
      if (MUL_EN) begin
         repeat (7) @(posedge clk);
         #2;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy_before_rst", busy, 1'b1);
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      check("abort_req_ready", req_ready, 1'b1);
      check("abort_rsp_valid", rsp_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_mux_sel", mux_sel, 4'h0);
      check("abort_rsp_data", rsp_data, 16'h0000);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("abort_no_response", seen, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
